// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single-port
// memory. Each access occupies the memory port for one ACCESS cycle; reads
// add one RDWAIT cycle to capture mem_rdata and return it to the requester.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   req_i/req_we_i      per-requester request and write flag
//   req_addr_i/_wdata_i per-requester address and write data
//   gnt_o               one-cycle pulse while the requester's access is on the port
//   rsp_valid_o         one-cycle pulse qualifying rsp_rdata_o for a requester
//   rsp_rdata_o         shared read data, held until the next capture
//   mem_addr/mem_wdata  memory address/data, held outside ACCESS
//   mem_wr_en/mem_rd_en memory strobes, only during ACCESS
//   mem_rdata           memory read data, valid the cycle after mem_rd_en
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_i,
  input  logic [1:0]             req_we_i,
  input  logic [1:0][ADDR_W-1:0] req_addr_i,
  input  logic [1:0][DATA_W-1:0] req_wdata_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rsp_valid_o,
  output logic [DATA_W-1:0]      rsp_rdata_o,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_wr_en,
  output logic                   mem_rd_en,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  // Last granted requester. It is also the owner of the access in flight,
  // so RDWAIT routes rsp_valid_o with it directly.
  logic              last_q, last_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rv_q, rv_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              win;

  // On a tie the requester not granted last wins; otherwise the sole requester.
  assign win = (req_i == 2'b11) ? ~last_q : req_i[1];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = 2'b00;
    rv_d    = 2'b00;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          // Latch straight into the output registers so ACCESS drives them.
          last_d  = win;
          gnt_d   = 2'b01 << win;
          addr_d  = req_addr_i[win];
          wdata_d = req_wdata_i[win];
          wr_d    = req_we_i[win];
          rd_d    = ~req_we_i[win];
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = rd_q ? RDWAIT : IDLE;
      RDWAIT: begin
        rdata_d = mem_rdata;
        rv_d    = 2'b01 << last_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      rv_q    <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rsp_valid_o = rv_q;
  assign rsp_rdata_o = rdata_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wr_en   = wr_q;
  assign mem_rd_en   = rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run scored
// against a cycle-scheduled transaction model and a small memory.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [1:0]         req = '0;
  logic [1:0]         we = '0;
  logic [1:0][AW-1:0] addr = '0;
  logic [1:0][DW-1:0] wdata = '0;
  logic [1:0]         gnt, rv;
  logic [DW-1:0]      rdata, mwdata;
  logic [AW-1:0]      maddr;
  logic               wr, rd;
  logic [DW-1:0]      mrdata = '0;
  logic [DW-1:0]      tmem [256] = '{default: '0};

  int n_chk = 0;
  int n_fail = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_i(req), .req_we_i(we), .req_addr_i(addr), .req_wdata_i(wdata),
    .gnt_o(gnt), .rsp_valid_o(rv), .rsp_rdata_o(rdata),
    .mem_addr(maddr), .mem_wr_en(wr), .mem_rd_en(rd), .mem_wdata(mwdata),
    .mem_rdata(mrdata)
  );

  always #5 clk = ~clk;

  // Bench memory: synchronous write, read data registered one cycle after rd.
  always @(posedge clk) begin
    if (wr) tmem[maddr[7:0]] <= mwdata;
    if (rd) mrdata <= tmem[maddr[7:0]];
  end

  // Protocol monitor: strobe exclusivity, one-hot grants/responses, and each
  // read grant answered by exactly one rsp_valid two cycles later.
  logic [1:0] rvp1 = '0, rvp2 = '0;
  always @(negedge clk) begin
    if (!reset) begin
      rvp1 = '0;
      rvp2 = '0;
    end else begin
      n_chk++;
      if ((wr && rd) || ((wr || rd) !== (gnt != 2'b00))) begin
        n_fail++;
        $display("FAIL mon_strobes: got wr=%b rd=%b gnt=%b, want exclusive strobes only with a grant", wr, rd, gnt);
      end
      n_chk++;
      if (gnt == 2'b11 || rv == 2'b11) begin
        n_fail++;
        $display("FAIL mon_onehot: got gnt=%b rsp_valid=%b, want at most one bit each", gnt, rv);
      end
      n_chk++;
      if (rv !== rvp2) begin
        n_fail++;
        $display("FAIL mon_rsp_follow: got rsp_valid=%b, want %b", rv, rvp2);
      end
      rvp2 = rvp1;
      rvp1 = rd ? gnt : 2'b00;
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    req = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req = 2'b11;
    we = 2'b11;
    #1;
    n_chk++;
    if ({gnt, rv, rdata, maddr, wr, rd, mwdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got gnt=%b rv=%b rdata=%h addr=%h wr=%b rd=%b wdata=%h, want all 0",
               gnt, rv, rdata, maddr, wr, rd, mwdata);
    end
    req = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_chk++;
    if ({gnt, rv, wr, rd} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got gnt=%b rv=%b wr=%b rd=%b, want 0", gnt, rv, wr, rd);
    end
  endtask

  task automatic test_write;
    req = 2'b01; we = 2'b01;
    addr[0] = 16'h0010; wdata[0] = 32'hDEADBEEF;
    tick();
    n_chk++;
    if ({wr, rd, gnt, maddr, mwdata} !== {1'b1, 1'b0, 2'b01, 16'h0010, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL write_access: got wr=%b rd=%b gnt=%b addr=%h wdata=%h, want 1 0 01 0010 deadbeef",
               wr, rd, gnt, maddr, mwdata);
    end
    req = 2'b00;
    tick();
    n_chk++;
    if ({wr, rd, gnt, maddr, mwdata} !== {1'b0, 1'b0, 2'b00, 16'h0010, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL write_idle_hold: got wr=%b rd=%b gnt=%b addr=%h wdata=%h, want 0 0 00 0010 deadbeef",
               wr, rd, gnt, maddr, mwdata);
    end
  endtask

  task automatic test_read;
    // Port 0 carries junk fields without a request; they must be ignored.
    req = 2'b10; we = 2'b01;
    addr[0] = 16'h0055; addr[1] = 16'h0010;
    tick();
    n_chk++;
    if ({wr, rd, gnt, maddr} !== {1'b0, 1'b1, 2'b10, 16'h0010}) begin
      n_fail++;
      $display("FAIL read_access: got wr=%b rd=%b gnt=%b addr=%h, want 0 1 10 0010", wr, rd, gnt, maddr);
    end
    req = 2'b00;
    tick();
    n_chk++;
    if ({wr, rd, gnt, rv} !== 6'b0) begin
      n_fail++;
      $display("FAIL read_wait: got wr=%b rd=%b gnt=%b rv=%b, want all 0", wr, rd, gnt, rv);
    end
    tick();
    n_chk++;
    if ({rv, rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL read_rsp: got rv=%b rdata=%h, want 10 deadbeef", rv, rdata);
    end
    tick();
    n_chk++;
    if ({rv, rdata} !== {2'b00, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL read_hold: got rv=%b rdata=%h, want 00 deadbeef", rv, rdata);
    end
  endtask

  task automatic test_alternate;
    int q[$];
    do_reset();
    req = 2'b11; we = 2'b11;
    addr[0] = 16'h0020; addr[1] = 16'h0021;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (gnt != 2'b00) q.push_back(gnt == 2'b10 ? 1 : 0);
    end
    req = 2'b00;
    n_chk++;
    if (q.size() != 6) begin
      n_fail++;
      $display("FAIL alt_count: got %0d grants, want 6", q.size());
    end
    for (int i = 0; i < q.size(); i++) begin
      n_chk++;
      if (q[i] != i % 2) begin
        n_fail++;
        $display("FAIL alt_order: grant %0d got req%0d, want req%0d", i, q[i], i % 2);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back;
    int n = 0;
    logic [AW-1:0] ea;
    do_reset();
    req = 2'b01; we = 2'b01;
    addr[0] = 16'h0100; wdata[0] = 32'h1000_0000;
    ea = addr[0];
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++;
      if (gnt !== ((i % 2 == 0) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL b2b_gnt: cycle %0d got gnt=%b, want %b", i, gnt, (i % 2 == 0) ? 2'b01 : 2'b00);
      end
      if (gnt[0]) begin
        n++;
        n_chk++;
        if (maddr !== ea || wr !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_addr: got addr=%h wr=%b, want %h 1", maddr, wr, ea);
        end
        addr[0] = addr[0] + 16'd1;
        wdata[0] = wdata[0] + 32'd1;
        ea = addr[0];
      end
    end
    req = 2'b00;
    n_chk++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d writes in 8 cycles, want 4", n);
    end
    tick();
  endtask

  task automatic test_reset_rdwait;
    do_reset();
    req = 2'b01; we = 2'b00; addr[0] = 16'h0010;
    tick();
    n_chk++;
    if ({rd, gnt} !== 3'b101) begin
      n_fail++;
      $display("FAIL rst_rd_access: got rd=%b gnt=%b, want 1 01", rd, gnt);
    end
    req = 2'b00;
    tick();
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({gnt, rv, rdata, maddr, wr, rd, mwdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_rdwait_async: got gnt=%b rv=%b rdata=%h addr=%h wr=%b rd=%b, want all 0",
               gnt, rv, rdata, maddr, wr, rd);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (rv !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_no_rsp: cycle %0d got rv=%b, want 00", i, rv);
      end
    end
    req = 2'b11; we = 2'b11;
    tick();
    n_chk++;
    if (gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_first_tie: got gnt=%b, want 01", gnt);
    end
    req = 2'b00;
    tick();
  endtask

  // Reference model: each accepted request reserves the port for 2 (write) or
  // 3 (read) cycles; expected outputs are booked into a per-cycle schedule.
  task automatic test_random;
    logic [1:0]    s_gnt [8];
    logic          s_wr [8], s_rd [8];
    logic [AW-1:0] s_addr [8];
    logic [DW-1:0] s_wd [8];
    logic [1:0]    s_rv [8];
    logic [DW-1:0] s_rd_data [8];
    logic [DW-1:0] mm [256];
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wd = '0, h_rdata = '0;
    int cyc = 0, next_ok = 0, last = 1, w, sl;
    logic [1:0] eg;
    for (int i = 0; i < 8; i++) begin
      s_gnt[i] = '0; s_wr[i] = 0; s_rd[i] = 0; s_rv[i] = '0;
      s_addr[i] = '0; s_wd[i] = '0; s_rd_data[i] = '0;
    end
    do_reset();
    mm = tmem;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      cyc++;
      if (cyc >= next_ok && req != 2'b00) begin
        if (req == 2'b11) w = 1 - last;
        else w = req[1] ? 1 : 0;
        last = w;
        sl = cyc % 8;
        s_gnt[sl] = (w == 1) ? 2'b10 : 2'b01;
        s_wr[sl] = we[w];
        s_rd[sl] = !we[w];
        s_addr[sl] = addr[w];
        s_wd[sl] = wdata[w];
        if (we[w]) begin
          mm[addr[w][7:0]] = wdata[w];
          next_ok = cyc + 2;
        end else begin
          s_rv[(cyc + 2) % 8] = s_gnt[sl];
          s_rd_data[(cyc + 2) % 8] = mm[addr[w][7:0]];
          next_ok = cyc + 3;
        end
      end
      @(negedge clk);
      sl = cyc % 8;
      eg = s_gnt[sl];
      if (eg != 2'b00) begin h_addr = s_addr[sl]; h_wd = s_wd[sl]; end
      if (s_rv[sl] != 2'b00) h_rdata = s_rd_data[sl];
      n_chk++;
      if ({gnt, wr, rd, maddr, mwdata} !== {eg, s_wr[sl], s_rd[sl], h_addr, h_wd}) begin
        n_fail++;
        $display("FAIL rand_port: cyc %0d got gnt=%b wr=%b rd=%b addr=%h wd=%h, want %b %b %b %h %h",
                 cyc, gnt, wr, rd, maddr, mwdata, eg, s_wr[sl], s_rd[sl], h_addr, h_wd);
      end
      n_chk++;
      if ({rv, rdata} !== {s_rv[sl], h_rdata}) begin
        n_fail++;
        $display("FAIL rand_rsp: cyc %0d got rv=%b rdata=%h, want %b %h", cyc, rv, rdata, s_rv[sl], h_rdata);
      end
      s_gnt[sl] = '0; s_wr[sl] = 0; s_rd[sl] = 0; s_rv[sl] = '0;
      // Requesters: hold until granted, then maybe issue another.
      for (int i = 0; i < 2; i++) begin
        if (eg[i] || !req[i]) begin
          req[i] = ($urandom_range(0, 9) < 6);
          we[i] = 1'($urandom_range(0, 1));
          addr[i] = req[i] ? 16'($urandom_range(0, 31)) : 16'($urandom);
          wdata[i] = $urandom;
        end
      end
    end
    req = 2'b00;
    tick();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alternate();
    test_back_to_back();
    test_reset_rdwait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
